// File: rtl/atr_header_probe_if.sv
// SD block interface between hps_io and the drive side.
//   sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr : hps_io -> probe (transfer handshake and bytes)
//   sd_lba, sd_rd, sd_wr                           : probe -> hps_io (block request)
//   zpu_overlap                                    : probe -> observer, a ZPU request edge was deferred
interface atr_header_probe_if #(
  parameter int unsigned VDNUM = 3
) ();
  logic             sd_ack;
  logic [8:0]       sd_buff_addr;
  logic [7:0]       sd_buff_dout;
  logic             sd_buff_wr;
  logic [31:0]      sd_lba;
  logic [VDNUM-1:0] sd_rd;
  logic [VDNUM-1:0] sd_wr;
  logic             zpu_overlap;

  modport master (
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output sd_lba, sd_rd, sd_wr, zpu_overlap
  );

  modport slave (
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  sd_lba, sd_rd, sd_wr, zpu_overlap
  );
endinterface

// File: rtl/atr_header_probe.sv
// On each image mount, reads sector 0, parses the 16-byte ATR header and publishes
// drive geometry with a one-cycle done pulse. While probing it owns the SD request
// path; otherwise ZPU requests are forwarded with one cycle of latency.
//   clk_sys, reset      : clock, synchronous active-high reset
//   img_mounted/size    : per-drive mount strobe and image size
//   sd                  : SD block interface (master side)
//   zpu_lba/rd/wr       : ZPU bridge block request
//   busy                : probe owns the SD path
//   hdr_*               : probe result (done pulse, drive, valid, error, fields)
module atr_header_probe #(
  parameter int unsigned VDNUM   = 3,
  parameter int unsigned TIMEOUT = 28000000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [VDNUM-1:0]   img_mounted,
  input  logic [63:0]        img_size,
  atr_header_probe_if.master sd,
  input  logic [31:0]        zpu_lba,
  input  logic [VDNUM-1:0]   zpu_rd,
  input  logic [VDNUM-1:0]   zpu_wr,
  output logic               busy,
  output logic               hdr_done,
  output logic [1:0]         hdr_drive,
  output logic               hdr_valid,
  output logic [1:0]         hdr_error,
  output logic [15:0]        hdr_sector_size,
  output logic [27:0]        hdr_image_bytes,
  output logic [7:0]         hdr_flags
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = 2;
  localparam int unsigned ZW = 2 * VDNUM;

  typedef enum logic [2:0] {WAITQ, IDLE, REQ, XFER, CHECK, DONE} state_t;

  state_t           state;
  logic [VDNUM-1:0] pend;
  logic [63:0]      pend_size [VDNUM];
  logic [63:0]      cur_size;
  logic [DW-1:0]    drv;
  logic [1:0]       err;
  logic [TW-1:0]    timer;
  logic [7:0]       hdr [16];
  logic [ZW-1:0]    zpu_prev;
  logic [ZW-1:0]    zpu_now;

  logic             pick_vld;
  logic [DW-1:0]    pick_idx;
  logic [27:0]      img_bytes_c;
  logic [63:0]      need_c;
  logic             tmo_c;

  assign zpu_now     = {zpu_rd, zpu_wr};
  assign img_bytes_c = {hdr[6], hdr[3], hdr[2], 4'b0000};
  assign need_c      = 64'(img_bytes_c) + 64'd16;
  assign tmo_c       = (timer == TW'(TIMEOUT - 1));

  // Lowest-index pending mount
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = int'(VDNUM) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        pick_vld = 1'b1;
        pick_idx = DW'(i);
      end
    end
  end

  // Probe FSM with registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= WAITQ;
      pend            <= '0;
      cur_size        <= '0;
      drv             <= '0;
      err             <= '0;
      timer           <= '0;
      zpu_prev        <= '0;
      sd.sd_lba       <= '0;
      sd.sd_rd        <= '0;
      sd.sd_wr        <= '0;
      sd.zpu_overlap  <= 1'b0;
      busy            <= 1'b0;
      hdr_done        <= 1'b0;
      hdr_drive       <= '0;
      hdr_valid       <= 1'b0;
      hdr_error       <= '0;
      hdr_sector_size <= '0;
      hdr_image_bytes <= '0;
      hdr_flags       <= '0;
      for (int i = 0; i < 16; i++) hdr[i] <= '0;
      for (int i = 0; i < int'(VDNUM); i++) pend_size[i] <= '0;
    end else begin
      hdr_done <= 1'b0;
      zpu_prev <= zpu_now;
      // ZPU holds its request level, so a deferred edge only needs flagging
      if (busy && ((zpu_now & ~zpu_prev) != '0)) sd.zpu_overlap <= 1'b1;

      case (state)
        WAITQ: begin
          // ignore an ack still in flight from before reset
          if (!sd.sd_ack) state <= IDLE;
        end

        IDLE: begin
          sd.sd_lba      <= zpu_lba;
          sd.sd_rd       <= zpu_rd;
          sd.sd_wr       <= zpu_wr;
          sd.zpu_overlap <= 1'b0;
          // a forwarded ZPU transfer with ack high finishes before the next probe
          if (pick_vld && !sd.sd_ack) begin
            pend[pick_idx] <= 1'b0;
            drv            <= pick_idx;
            cur_size       <= pend_size[pick_idx];
            if (pend_size[pick_idx] == 64'd0) begin
              hdr_valid <= 1'b0;
            end else if (pend_size[pick_idx] < 64'd16) begin
              err   <= 2'd3;
              state <= DONE;
            end else begin
              busy      <= 1'b1;
              sd.sd_lba <= '0;
              sd.sd_rd  <= VDNUM'(1) << pick_idx;
              sd.sd_wr  <= '0;
              timer     <= '0;
              state     <= REQ;
            end
          end
        end

        REQ: begin
          if (sd.sd_ack) begin
            sd.sd_rd <= '0;
            timer    <= '0;
            state    <= XFER;
          end else if (tmo_c) begin
            sd.sd_rd <= '0;
            err      <= 2'd2;
            state    <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        XFER: begin
          if (sd.sd_buff_wr && (sd.sd_buff_addr < 9'd16))
            hdr[sd.sd_buff_addr[3:0]] <= sd.sd_buff_dout;
          if (!sd.sd_ack) begin
            state <= CHECK;
          end else if (tmo_c) begin
            err   <= 2'd2;
            state <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        CHECK: begin
          hdr_sector_size <= {hdr[5], hdr[4]};
          hdr_image_bytes <= img_bytes_c;
          hdr_flags       <= hdr[15];
          if ((hdr[0] != 8'h96) || (hdr[1] != 8'h02)) err <= 2'd1;
          else if (cur_size < need_c)                 err <= 2'd3;
          else                                        err <= 2'd0;
          state <= DONE;
        end

        DONE: begin
          hdr_done  <= 1'b1;
          hdr_valid <= (err == 2'd0);
          hdr_drive <= drv;
          hdr_error <= err;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= WAITQ;
      endcase

      // new strobes win over the pending-bit clear above
      for (int i = 0; i < int'(VDNUM); i++) begin
        if (img_mounted[i]) begin
          pend[i]      <= 1'b1;
          pend_size[i] <= img_size;
        end
      end
    end
  end

endmodule

// File: tb/tb_atr_header_probe.sv
module tb_atr_header_probe;
  localparam int unsigned VDNUM = 3;
  localparam int unsigned TMO   = 100;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [2:0]  img_mounted;
  logic [63:0] img_size;
  logic [31:0] zpu_lba;
  logic [2:0]  zpu_rd, zpu_wr;
  logic        busy, hdr_done, hdr_valid;
  logic [1:0]  hdr_drive, hdr_error;
  logic [15:0] hdr_sector_size;
  logic [27:0] hdr_image_bytes;
  logic [7:0]  hdr_flags;

  atr_header_probe_if #(.VDNUM(VDNUM)) sd ();

  atr_header_probe #(.VDNUM(VDNUM), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .sd(sd), .zpu_lba(zpu_lba), .zpu_rd(zpu_rd), .zpu_wr(zpu_wr), .busy(busy),
    .hdr_done(hdr_done), .hdr_drive(hdr_drive), .hdr_valid(hdr_valid), .hdr_error(hdr_error),
    .hdr_sector_size(hdr_sector_size), .hdr_image_bytes(hdr_image_bytes), .hdr_flags(hdr_flags)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_fail = 0;
  int dbl_done = 0;
  int bad_fwd = 0;
  bit zpu_block = 1'b0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [1:0]   drv;
    logic [63:0]  size;
    logic [127:0] h;
    logic [1:0]   err;
    logic         valid;
    logic [15:0]  sec;
    logic [27:0]  img;
    logic [7:0]   flags;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [127:0] mk_hdr(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b15);
    logic [127:0] r;
    r = '0;
    r[7:0] = b0;   r[15:8] = b1;  r[23:16] = b2; r[31:24] = b3;
    r[39:32] = b4; r[47:40] = b5; r[55:48] = b6; r[127:120] = b15;
    return r;
  endfunction

  function automatic vec_t mk_vec(input logic [1:0] d, input logic [63:0] s, input logic [127:0] h,
                                  input logic [1:0] e, input logic v, input logic [15:0] sec,
                                  input logic [27:0] img, input logic [7:0] fl);
    vec_t r;
    r.drv = d; r.size = s; r.h = h; r.err = e; r.valid = v; r.sec = sec; r.img = img; r.flags = fl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // hdr_done must never be high two cycles running; forwarding of the ZPU read blocked in test 5
  always @(negedge clk_sys) begin
    if (!reset && hdr_done && prev_done) dbl_done++;
    prev_done = hdr_done;
    if (zpu_block && sd.sd_rd == 3'b100) bad_fwd++;
  end

  task automatic mount(input logic [1:0] d, input logic [63:0] s);
    @(negedge clk_sys);
    img_mounted = 3'b001 << d;
    img_size    = s;
    @(negedge clk_sys);
    img_mounted = 3'b000;
  endtask

  // hps_io model: answers one sector-0 read, sends 20 bytes (last 4 beyond the header)
  task automatic serve(input logic [2:0] exp_rd, input logic [127:0] h,
                       input int mid_drv, input logic [63:0] mid_size);
    int n;
    n = 0;
    while (sd.sd_rd == 3'b000 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("req_seen", 64'(sd.sd_rd != 3'b000), 64'd1);
    if (sd.sd_rd == 3'b000) return;
    chk("req_rd", 64'(sd.sd_rd), 64'(exp_rd));
    chk("req_lba", 64'(sd.sd_lba), 64'd0);
    chk("req_busy", 64'(busy), 64'd1);
    sd.sd_ack = 1'b1;
    @(negedge clk_sys);
    chk("rd_drop", 64'(sd.sd_rd), 64'd0);
    for (int a = 0; a < 20; a++) begin
      sd.sd_buff_addr = 9'(a);
      sd.sd_buff_dout = (a < 16) ? h[8*a +: 8] : 8'hFF;
      sd.sd_buff_wr   = 1'b1;
      if (mid_drv >= 0 && a == 5) begin
        img_mounted = 3'b001 << mid_drv;
        img_size    = mid_size;
        zpu_rd      = 3'b100;
        zpu_lba     = 32'h0000_1234;
      end
      @(negedge clk_sys);
      img_mounted = 3'b000;
    end
    sd.sd_buff_wr = 1'b0;
    sd.sd_ack     = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_done(input int budget, output bit got, output int cyc, output bit saw_rd);
    got = 1'b0; saw_rd = 1'b0; cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk_sys);
      cyc++;
      if (sd.sd_rd != 3'b000) saw_rd = 1'b1;
      if (hdr_done) got = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, saw;
    int cyc;
    logic [127:0] ok_h;
    ok_h = mk_hdr(8'h96, 8'h02, 8'h80, 8'h16, 8'h80, 8'h00, 8'h00, 8'h00);

    vecs[0] = mk_vec(2'd0, 64'd92176, ok_h, 2'd0, 1'b1, 16'd128, 28'd92160, 8'h00);
    vecs[1] = mk_vec(2'd0, 64'd92176, mk_hdr(8'h00, 8'h00, 8'h80, 8'h16, 8'h80, 8'h00, 8'h00, 8'h00),
                     2'd1, 1'b0, 16'd128, 28'd92160, 8'h00);
    vecs[2] = mk_vec(2'd1, 64'd40000, ok_h, 2'd3, 1'b0, 16'd128, 28'd92160, 8'h00);
    vecs[3] = mk_vec(2'd2, 64'd92175, ok_h, 2'd3, 1'b0, 16'd128, 28'd92160, 8'h00);
    vecs[4] = mk_vec(2'd2, 64'd1056832, mk_hdr(8'h96, 8'h02, 8'h03, 8'h02, 8'h00, 8'h01, 8'h01, 8'hA5),
                     2'd0, 1'b1, 16'd256, 28'd1056816, 8'hA5);
    vecs[5] = mk_vec(2'd1, 64'd92176, mk_hdr(8'h96, 8'h03, 8'h80, 8'h16, 8'h80, 8'h00, 8'h00, 8'h11),
                     2'd1, 1'b0, 16'd128, 28'd92160, 8'h11);
    vecs[6] = mk_vec(2'd0, 64'd268435455, mk_hdr(8'h96, 8'h02, 8'hFF, 8'hFF, 8'h34, 8'h12, 8'hFF, 8'h3C),
                     2'd3, 1'b0, 16'h1234, 28'hFFFFFF0, 8'h3C);
    vecs[7] = mk_vec(2'd0, 64'h1_0000_0000, mk_hdr(8'h96, 8'h02, 8'hFF, 8'hFF, 8'h34, 8'h12, 8'hFF, 8'h3C),
                     2'd0, 1'b1, 16'h1234, 28'hFFFFFF0, 8'h3C);

    reset = 1'b1; img_mounted = '0; img_size = '0; zpu_lba = '0; zpu_rd = '0; zpu_wr = '0;
    sd.sd_ack = 1'b0; sd.sd_buff_addr = '0; sd.sd_buff_dout = '0; sd.sd_buff_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_sd_rd", 64'(sd.sd_rd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({hdr_done, hdr_valid, hdr_error, hdr_drive, hdr_flags}), 64'd0);
    chk("rst_fields", 64'({hdr_sector_size, hdr_image_bytes}), 64'd0);

    // table-driven header probes
    for (int i = 0; i < 8; i++) begin
      mount(vecs[i].drv, vecs[i].size);
      serve(3'b001 << vecs[i].drv, vecs[i].h, -1, 64'd0);
      wait_done(20, got, cyc, saw);
      chk($sformatf("v%0d_done", i), 64'(got), 64'd1);
      chk($sformatf("v%0d_valid", i), 64'(hdr_valid), 64'(vecs[i].valid));
      chk($sformatf("v%0d_err", i), 64'(hdr_error), 64'(vecs[i].err));
      chk($sformatf("v%0d_drive", i), 64'(hdr_drive), 64'(vecs[i].drv));
      chk($sformatf("v%0d_sec", i), 64'(hdr_sector_size), 64'(vecs[i].sec));
      chk($sformatf("v%0d_img", i), 64'(hdr_image_bytes), 64'(vecs[i].img));
      chk($sformatf("v%0d_flags", i), 64'(hdr_flags), 64'(vecs[i].flags));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
    end

    // zero-size image: clears valid, no read, no pulse
    mount(2'd2, 64'd0);
    wait_done(15, got, cyc, saw);
    chk("zero_no_done", 64'(got), 64'd0);
    chk("zero_no_rd", 64'(saw), 64'd0);
    chk("zero_valid", 64'(hdr_valid), 64'd0);

    // tiny image: size error without any read
    mount(2'd1, 64'd8);
    wait_done(20, got, cyc, saw);
    chk("tiny_done", 64'(got), 64'd1);
    chk("tiny_no_rd", 64'(saw), 64'd0);
    chk("tiny_err", 64'(hdr_error), 64'd3);
    chk("tiny_drive", 64'(hdr_drive), 64'd1);
    chk("tiny_valid", 64'(hdr_valid), 64'd0);

    // timeout: hps_io never acknowledges
    mount(2'd0, 64'd92176);
    @(negedge clk_sys);
    chk("tmo_req", 64'(sd.sd_rd), 64'd1);
    wait_done(150, got, cyc, saw);
    chk("tmo_done", 64'(got), 64'd1);
    chk("tmo_window", 64'(cyc >= 95 && cyc <= 110), 64'd1);
    chk("tmo_err", 64'(hdr_error), 64'd2);
    chk("tmo_rd_drop", 64'(sd.sd_rd), 64'd0);
    chk("tmo_valid", 64'(hdr_valid), 64'd0);

    // mount of drv1 during drv0 transfer while ZPU read of drive 2 is held
    zpu_block = 1'b1;
    mount(2'd0, 64'd92176);
    serve(3'b001, ok_h, 1, 64'd92176);
    wait_done(20, got, cyc, saw);
    chk("ov_d0_done", 64'(got), 64'd1);
    chk("ov_d0_drive", 64'(hdr_drive), 64'd0);
    chk("ov_d0_valid", 64'(hdr_valid), 64'd1);
    serve(3'b010, ok_h, -1, 64'd0);
    wait_done(20, got, cyc, saw);
    chk("ov_d1_done", 64'(got), 64'd1);
    chk("ov_d1_drive", 64'(hdr_drive), 64'd1);
    zpu_block = 1'b0;
    @(negedge clk_sys);
    chk("ov_fwd_rd", 64'(sd.sd_rd), 64'd4);
    chk("ov_fwd_lba", 64'(sd.sd_lba), 64'h1234);
    chk("ov_fwd_busy", 64'(busy), 64'd0);
    chk("ov_no_early_fwd", 64'(bad_fwd), 64'd0);
    zpu_rd = 3'b000;
    repeat (2) @(negedge clk_sys);

    // reset mid-transfer with ack held high
    mount(2'd0, 64'd92176);
    @(negedge clk_sys);
    sd.sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    chk("mr_rd", 64'(sd.sd_rd), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_outs", 64'({hdr_done, hdr_valid, hdr_error}), 64'd0);
    zpu_rd  = 3'b001;
    zpu_lba = 32'h0000_0077;
    repeat (5) @(negedge clk_sys);
    chk("mr_waitq_hold", 64'(sd.sd_rd), 64'd0);
    sd.sd_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("mr_fwd_rd", 64'(sd.sd_rd), 64'd1);
    chk("mr_fwd_lba", 64'(sd.sd_lba), 64'h77);
    zpu_rd = 3'b000;
    repeat (2) @(negedge clk_sys);
    mount(2'd0, 64'd92176);
    serve(3'b001, ok_h, -1, 64'd0);
    wait_done(20, got, cyc, saw);
    chk("mr_probe_done", 64'(got), 64'd1);
    chk("mr_probe_valid", 64'(hdr_valid), 64'd1);
    chk("mr_probe_err", 64'(hdr_error), 64'd0);

    chk("no_double_done", 64'(dbl_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
